// File: rtl/aes_key_expand_pkg.sv
// Shared AES-128 constants and small GF(2^8) / word helpers used by the key
// schedule and the cipher core.
package aes_key_expand_pkg;

  localparam int BLK_S = 128;
  localparam int KEY_S = 128;
  localparam int Nb    = 4;
  localparam int Nk    = 4;
  localparam int Nr    = 10;

  localparam logic [7:0] RCON_INIT = 8'h01;
  localparam logic [7:0] XTIME_RED = 8'h1B;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_EXPAND = 2'd1;
  localparam logic [1:0] ST_READY  = 2'd2;

  // Multiply by x in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? XTIME_RED : 8'h00);
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

endpackage

// File: rtl/aes_key_expand_if.sv
// Key-load and round-key read bus between the AXI-Stream front end / cipher
// core (master) and the key-schedule engine (slave).
interface aes_key_expand_if
  import aes_key_expand_pkg::*;
#(
  parameter int RK_AW = 4
) ();

  logic [0:KEY_S-1] key_in;
  logic             key_strobe;
  logic             key_busy;
  logic             key_ready;
  logic [RK_AW-1:0] rk_rd_addr;
  logic [0:BLK_S-1] rk_rd_data;

  modport master (
    output key_in,
    output key_strobe,
    output rk_rd_addr,
    input  key_busy,
    input  key_ready,
    input  rk_rd_data
  );

  modport slave (
    input  key_in,
    input  key_strobe,
    input  rk_rd_addr,
    output key_busy,
    output key_ready,
    output rk_rd_data
  );

endinterface

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box, one byte in, one byte out.
module aes_sbox (
  input  logic [7:0] din,
  output logic [7:0] dout
);

  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  assign dout = SBOX[din];

endmodule

// File: rtl/aes_key_expand.sv
// AES-128 key schedule: captures a key on key_strobe and writes one round key
// per clock into an internal file read through a registered port.
// Optional key cache: define AES_KEY_EXPAND_CACHE_EN to skip re-expansion of
// a repeated key while READY.
module aes_key_expand
  import aes_key_expand_pkg::*;
#(
  parameter int NR    = Nr,
  parameter int RK_AW = 4
) (
  input  logic             clk,
  input  logic             aresetn,
  aes_key_expand_if.slave  kx
);

  localparam logic [RK_AW-1:0] NR_A = RK_AW'(NR);

  logic [1:0]         state;
  logic [RK_AW-1:0]   round;
  logic [7:0]         rcon;
  logic [31:0]        w     [Nk];
  logic [31:0]        w_nxt [Nk];
  logic [32*Nb-1:0]   rk    [NR+1];
  logic [BLK_S-1:0]   rd_data_p1;

  logic [KEY_S-1:0]   key_p0;
  logic [31:0]        rot_p0;
  logic [31:0]        sub_p0;
  logic [31:0]        t_p0;
  logic [32*Nb-1:0]   rk_nxt;
  logic               hit;
  logic               capture;
  logic               expand_cyc;

  assign key_p0     = kx.key_in;
  assign expand_cyc = (state == ST_EXPAND);
  assign capture    = kx.key_strobe && !hit;

  // SubWord(RotWord(w3)) ^ Rcon
  assign rot_p0 = rot_word(w[Nk-1]);

  for (genvar g = 0; g < 4; g++) begin : g_subword
    aes_sbox u_sbox (
      .din  (rot_p0[8*g +: 8]),
      .dout (sub_p0[8*g +: 8])
    );
  end

  assign t_p0 = sub_p0 ^ {rcon, 24'h000000};

  always_comb begin
    w_nxt[0] = w[0] ^ t_p0;
    for (int i = 1; i < Nk; i++) begin
      w_nxt[i] = w[i] ^ w_nxt[i-1];
    end
  end

  assign rk_nxt = {w_nxt[0], w_nxt[1], w_nxt[2], w_nxt[3]};

`ifdef AES_KEY_EXPAND_CACHE_EN
  logic [KEY_S-1:0] last_key;
  logic             last_vld;

  // A strobe during EXPAND is never a hit because the state check fails.
  assign hit = (state == ST_READY) && last_vld && (key_p0 == last_key);

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      last_vld <= 1'b0;
    end else if (expand_cyc && !capture && (round == NR_A)) begin
      last_vld <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (expand_cyc && !capture && (round == NR_A)) begin
      last_key <= rk[0];
    end
  end
`else
  assign hit = 1'b0;
`endif

  // Control: FSM, round counter and rcon
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state <= ST_IDLE;
      round <= '0;
      rcon  <= RCON_INIT;
    end else if (capture) begin
      state <= ST_EXPAND;
      round <= RK_AW'(1);
      rcon  <= RCON_INIT;
    end else if (expand_cyc) begin
      round <= round + RK_AW'(1);
      rcon  <= xtime(rcon);
      if (round == NR_A) begin
        state <= ST_READY;
      end
    end
  end

  // Datapath: working words and the round-key file carry no reset
  always_ff @(posedge clk) begin
    if (capture) begin
      rk[0] <= key_p0;
      for (int i = 0; i < Nk; i++) begin
        w[i] <= key_p0[32*(Nk-1-i) +: 32];
      end
    end else if (expand_cyc) begin
      rk[round] <= rk_nxt;
      for (int i = 0; i < Nk; i++) begin
        w[i] <= w_nxt[i];
      end
    end
  end

  // Registered read port, one cycle latency
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      rd_data_p1 <= '0;
    end else if (kx.rk_rd_addr <= NR_A) begin
      rd_data_p1 <= rk[kx.rk_rd_addr];
    end else begin
      rd_data_p1 <= '0;
    end
  end

  assign kx.rk_rd_data = rd_data_p1;
  assign kx.key_busy   = (state == ST_EXPAND);
  assign kx.key_ready  = (state == ST_READY);

endmodule

// File: tb/tb_aes_key_expand.sv
// Directed bench for aes_key_expand using FIPS-197 A.1 and all-zero key vectors.
module tb_aes_key_expand;

  localparam logic [127:0] KEY_A1  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] A1_RK1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] A1_RK2  = 128'hf2c295f27a96b9435935807a7359f67f;
  localparam logic [127:0] A1_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] KEY_Z   = 128'h0;
  localparam logic [127:0] Z_RK1   = 128'h62636363626363636263636362636363;
  localparam logic [127:0] Z_RK10  = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

`ifdef AES_KEY_EXPAND_CACHE_EN
  localparam int RESTROBE_LOW = 0;
`else
  localparam int RESTROBE_LOW = 10;
`endif

  logic clk = 1'b0;
  logic aresetn;
  int   n_vec = 0;
  int   n_err = 0;

  aes_key_expand_if #(.RK_AW(4)) bus ();

  aes_key_expand #(.NR(10), .RK_AW(4)) dut (
    .clk     (clk),
    .aresetn (aresetn),
    .kx      (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic strobe(input logic [127:0] k);
    bus.key_in     = k;
    bus.key_strobe = 1'b1;
    @(posedge clk); #1;
    bus.key_strobe = 1'b0;
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (!bus.key_ready && n < 30) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic rd(input logic [3:0] a, output logic [127:0] d);
    bus.rk_rd_addr = a;
    @(posedge clk); #1;
    d = bus.rk_rd_data;
  endtask

  initial begin
    int           n;
    int           low;
    logic [127:0] d;

    bus.key_in     = '0;
    bus.key_strobe = 1'b0;
    bus.rk_rd_addr = '0;
    aresetn        = 1'b0;
    #12;
    check("rst_busy",  128'(bus.key_busy),  128'(0));
    check("rst_ready", 128'(bus.key_ready), 128'(0));
    check("rst_rdata", bus.rk_rd_data, 128'(0));
    aresetn = 1'b1;
    @(posedge clk); #1;
    check("idle_busy",  128'(bus.key_busy),  128'(0));
    check("idle_ready", 128'(bus.key_ready), 128'(0));

    // Test 1: FIPS-197 A.1
    strobe(KEY_A1);
    check("t1_busy",  128'(bus.key_busy),  128'(1));
    check("t1_ready0", 128'(bus.key_ready), 128'(0));
    wait_ready(n);
    check("t1_latency", 128'(n), 128'(10));
    check("t1_busy_done", 128'(bus.key_busy), 128'(0));
    rd(4'd1, d);  check("t1_rk1", d, A1_RK1);
    rd(4'd2, d);  check("t1_rk2", d, A1_RK2);
    rd(4'd10, d); check("t1_rk10", d, A1_RK10);

    // Test 3: back-to-back reads 0, 10, 15
    bus.rk_rd_addr = 4'd0;
    @(posedge clk); #1;
    check("t3_rd0", bus.rk_rd_data, KEY_A1);
    bus.rk_rd_addr = 4'd10;
    #1;
    check("t3_registered", bus.rk_rd_data, KEY_A1);
    @(posedge clk); #1;
    check("t3_rd10", bus.rk_rd_data, A1_RK10);
    bus.rk_rd_addr = 4'd15;
    @(posedge clk); #1;
    check("t3_rd15", bus.rk_rd_data, 128'(0));

    // Test 2: abort after 4 cycles, restart with all-zero key
    strobe(KEY_A1);
    repeat (3) @(posedge clk);
    #1;
    check("t2_busy_mid", 128'(bus.key_busy), 128'(1));
    strobe(KEY_Z);
    wait_ready(n);
    check("t2_latency", 128'(n), 128'(10));
    rd(4'd10, d); check("t2_rk10", d, Z_RK10);
    rd(4'd1, d);  check("t2_rk1", d, Z_RK1);

    // Strobe held two cycles: the key on the last high cycle is expanded
    bus.key_in     = KEY_Z;
    bus.key_strobe = 1'b1;
    @(posedge clk); #1;
    bus.key_in     = KEY_A1;
    @(posedge clk); #1;
    bus.key_strobe = 1'b0;
    wait_ready(n);
    check("held_latency", 128'(n), 128'(10));
    rd(4'd1, d);  check("held_rk1", d, A1_RK1);

    // Test 4: asynchronous reset at round 5
    strobe(KEY_Z);
    bus.rk_rd_addr = 4'd1;
    repeat (4) @(posedge clk);
    #1;
    check("t4_busy_pre", 128'(bus.key_busy), 128'(1));
    check("t4_rdata_pre", bus.rk_rd_data, Z_RK1);
    #2;
    aresetn = 1'b0;
    #1;
    check("t4_busy_rst",  128'(bus.key_busy),  128'(0));
    check("t4_ready_rst", 128'(bus.key_ready), 128'(0));
    check("t4_rdata_rst", bus.rk_rd_data, 128'(0));
    #3;
    aresetn = 1'b1;
    @(posedge clk); #1;
    check("t4_idle_busy",  128'(bus.key_busy),  128'(0));
    check("t4_idle_ready", 128'(bus.key_ready), 128'(0));
    strobe(KEY_A1);
    wait_ready(n);
    check("t4_latency", 128'(n), 128'(10));
    rd(4'd1, d);  check("t4_rk1", d, A1_RK1);
    rd(4'd10, d); check("t4_rk10", d, A1_RK10);

    // Test 5: re-strobe the same key while READY
    strobe(KEY_A1);
    low = bus.key_ready ? 0 : 1;
    repeat (11) begin
      @(posedge clk); #1;
      if (!bus.key_ready) low++;
    end
    check("t5_ready_low", 128'(low), 128'(RESTROBE_LOW));
    check("t5_ready_end", 128'(bus.key_ready), 128'(1));
    rd(4'd1, d);  check("t5_rk1", d, A1_RK1);
    rd(4'd10, d); check("t5_rk10", d, A1_RK10);
    rd(4'd0, d);  check("t5_rk0", d, KEY_A1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
